// File: rtl/fourbit_adder.sv
// Registered WIDTH-bit ripple-carry adder: {carry,sum} <= a + b + cin, one clock of latency.
// Optional FOURBIT_ADDER_OVF_EN adds a registered two's-complement overflow flag on port ovf.
module fourbit_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef FOURBIT_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (c & (x ^ y));
  endfunction

  logic [WIDTH:0]   c_d;
  logic [WIDTH-1:0] sum_d;
  logic             carry_d;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;

  // Combinational ripple chain: c_d[0] is the carry-in, c_d[WIDTH] the carry-out.
  always_comb begin
    c_d    = '0;
    sum_d  = '0;
    c_d[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum_d[i]  = fa_sum(a[i], b[i], c_d[i]);
      c_d[i+1]  = fa_carry(a[i], b[i], c_d[i]);
    end
    carry_d = c_d[WIDTH];
  end

  // Output register stage; reset overrides whatever the operands are that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign sum   = sum_q;
  assign carry = carry_q;

`ifdef FOURBIT_ADDER_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Signed overflow: carry into the sign cell differs from carry out of it.
  assign ovf_d = c_d[WIDTH] ^ c_d[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_fourbit_adder.sv
// Self-checking bench for fourbit_adder: directed cases, back-to-back and reset
// sequences, exhaustive and random operands against an arithmetic reference model.
module tb_fourbit_adder;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum;
  logic         carry;
`ifdef FOURBIT_ADDER_OVF_EN
  logic         ovf;
`endif

  int compared;
  int mismatched;

  fourbit_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .carry (carry)
`ifdef FOURBIT_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer addition; overflow from operand/result sign bits.
  function automatic logic [W+1:0] ref_model(input logic r, input logic [W-1:0] xa,
                                             input logic [W-1:0] xb, input logic xc);
    logic [W:0] full;
    logic       v;
    if (r) return '0;
    full = {1'b0, xa} + {1'b0, xb} + {{W{1'b0}}, xc};
    v    = (xa[W-1] == xb[W-1]) && (full[W-1] != xa[W-1]);
    return {v, full};
  endfunction

  task automatic check_sum(input string tag, input logic [W-1:0] exp_s);
    compared++;
    assert (sum === exp_s) else begin
      mismatched++;
      $error("FAIL %s sum: got %h expected %h", tag, sum, exp_s);
    end
  endtask

  task automatic check_carry(input string tag, input logic exp_c);
    compared++;
    assert (carry === exp_c) else begin
      mismatched++;
      $error("FAIL %s carry: got %b expected %b", tag, carry, exp_c);
    end
  endtask

  task automatic check_ovf(input string tag, input logic exp_v);
`ifdef FOURBIT_ADDER_OVF_EN
    compared++;
    assert (ovf === exp_v) else begin
      mismatched++;
      $error("FAIL %s ovf: got %b expected %b", tag, ovf, exp_v);
    end
`endif
  endtask

  // Drive one cycle of inputs, wait for the capturing edge, sample 1 time unit later.
  task automatic apply(input logic r, input logic [W-1:0] xa, input logic [W-1:0] xb,
                       input logic xc);
    rst = r; a = xa; b = xb; cin = xc;
    @(posedge clk);
    #1;
  endtask

  // Directed case with hand-written expectations.
  task automatic directed(input string tag, input logic r, input logic [W-1:0] xa,
                          input logic [W-1:0] xb, input logic xc,
                          input logic [W-1:0] es, input logic ec, input logic ev);
    apply(r, xa, xb, xc);
    check_sum(tag, es);
    check_carry(tag, ec);
    check_ovf(tag, ev);
  endtask

  // Case checked against the reference model.
  task automatic modeled(input string tag, input logic r, input logic [W-1:0] xa,
                         input logic [W-1:0] xb, input logic xc);
    logic [W+1:0] e;
    e = ref_model(r, xa, xb, xc);
    apply(r, xa, xb, xc);
    check_sum(tag, e[W-1:0]);
    check_carry(tag, e[W]);
    check_ovf(tag, e[W+1]);
  endtask

  initial begin
    logic [W-1:0] held_s;
    logic         held_c;
    compared   = 0;
    mismatched = 0;
    rst = 1'b1; a = '0; b = '0; cin = 1'b0;
    #1;

    // Reset held for two edges with all-ones operands.
    directed("rst0", 1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0);
    directed("rst1", 1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0);

    // First result right after release, then the listed directed cases.
    directed("0+0+1", 1'b0, 4'h0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0);
    directed("5+3+0", 1'b0, 4'h5, 4'h3, 1'b0, 4'h8, 1'b0, 1'b1);
    directed("F+1+0", 1'b0, 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0);
    directed("8+8+1", 1'b0, 4'h8, 4'h8, 1'b1, 4'h1, 1'b1, 1'b1);
    directed("F+F+0", 1'b0, 4'hF, 4'hF, 1'b0, 4'hE, 1'b1, 1'b0);
    directed("5+5+1", 1'b0, 4'h5, 4'h5, 1'b1, 4'hB, 1'b0, 1'b1);
    directed("F+F+1", 1'b0, 4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0);
    directed("F+0+1", 1'b0, 4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0);

    // Inputs changing between edges must not disturb the registered outputs.
    held_s = 4'h0; held_c = 1'b1;
    a = 4'h7; b = 4'h2; cin = 1'b0;
    #3;
    check_sum("hold", held_s);
    check_carry("hold", held_c);
    @(posedge clk);
    #1;
    check_sum("hold_load", 4'h9);
    check_carry("hold_load", 1'b0);

    // Back-to-back with a mid-stream reset pulse.
    modeled("b2b0", 1'b0, 4'h3, 4'hC, 1'b1);
    modeled("b2b1", 1'b0, 4'h9, 4'h9, 1'b0);
    directed("midrst", 1'b1, 4'hE, 4'h7, 1'b1, 4'h0, 1'b0, 1'b0);
    directed("resume", 1'b0, 4'h6, 4'h7, 1'b1, 4'hE, 1'b0, 1'b1);
    modeled("b2b2", 1'b0, 4'hA, 4'h6, 1'b0);

    // Exhaustive operand sweep.
    for (int i = 0; i < 512; i++) begin
      modeled("exh", 1'b0, W'(i >> 5), W'(i >> 1), i[0]);
    end

    // Random stream with occasional reset.
    for (int i = 0; i < 300; i++) begin
      modeled("rnd", ($urandom_range(0, 15) == 0), W'($urandom), W'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
